// File: rtl/rd_reorder_buf_if.sv
// Bus bundle for the read-response reorder buffer. It carries the core request
// path, the I/O request and response paths, and the in-order return path.
// The slave modport is the buffer itself. The master modport is the
// surrounding core/I/O environment.
interface rd_reorder_buf_if #(
  parameter int TAG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 58,
  parameter int DATA_WIDTH = 512
);
  logic                  cor_tx_rd_valid;
  logic [ADDR_WIDTH-1:0] cor_tx_rd_addr;
  logic                  rob_almostfull;
  logic                  spl_tx_rd_almostfull;
  logic                  io_tx_rd_valid;
  logic [ADDR_WIDTH-1:0] io_tx_rd_addr;
  logic [TAG_WIDTH-1:0]  io_tx_rd_tag;
  logic                  spl_rx_rd_valid;
  logic [TAG_WIDTH-1:0]  spl_rx_rd_tag;
  logic [DATA_WIDTH-1:0] spl_rx_data;
  logic                  io_rx_rd_valid;
  logic [DATA_WIDTH-1:0] io_rx_data;
  logic [TAG_WIDTH:0]    rob_occupancy;
  logic                  rob_err;

  modport slave (
    input  cor_tx_rd_valid, cor_tx_rd_addr, spl_tx_rd_almostfull,
           spl_rx_rd_valid, spl_rx_rd_tag, spl_rx_data,
    output rob_almostfull, io_tx_rd_valid, io_tx_rd_addr, io_tx_rd_tag,
           io_rx_rd_valid, io_rx_data, rob_occupancy, rob_err
  );

  modport master (
    output cor_tx_rd_valid, cor_tx_rd_addr, spl_tx_rd_almostfull,
           spl_rx_rd_valid, spl_rx_rd_tag, spl_rx_data,
    input  rob_almostfull, io_tx_rd_valid, io_tx_rd_addr, io_tx_rd_tag,
           io_rx_rd_valid, io_rx_data, rob_occupancy, rob_err
  );
endinterface

// File: rtl/rd_reorder_buf.sv
// Read-response reorder buffer. Each accepted core read gets a tag. Responses
// may come back from I/O in any order. Data is returned to the core strictly in
// request order, one beat per cycle, with no stall path from the core.
module rd_reorder_buf #(
  parameter int TAG_WIDTH  = 5,
  parameter int ADDR_WIDTH = 58,
  parameter int DATA_WIDTH = 512,
  parameter int AF_MARGIN  = 4
) (
  input  logic             CLK_400M,
  input  logic             spl_reset,
  rd_reorder_buf_if.slave  bus
);
  localparam int                 DEPTH       = 1 << TAG_WIDTH;
  localparam int                 OCC_W       = TAG_WIDTH + 1;
  localparam logic [OCC_W-1:0]   DEPTH_C     = {1'b1, {TAG_WIDTH{1'b0}}};
  localparam logic [OCC_W-1:0]   AF_MARGIN_C = OCC_W'(AF_MARGIN);
  localparam logic [OCC_W-1:0]   OCC_ONE_C   = OCC_W'(1);
  localparam logic [TAG_WIDTH-1:0] TAG_ONE_C = TAG_WIDTH'(1);

  logic [DEPTH-1:0]      pending_r;
  logic [DEPTH-1:0]      filled_r;
  logic [DEPTH-1:0]      pending_nxt_s;
  logic [DEPTH-1:0]      filled_nxt_s;
  logic [DATA_WIDTH-1:0] data_r [DEPTH];
  logic [TAG_WIDTH-1:0]  alloc_ptr_r;
  logic [TAG_WIDTH-1:0]  head_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic [OCC_W-1:0]      occ_nxt_s;
  logic                  alloc_s;
  logic                  drop_s;
  logic                  rsp_ok_s;
  logic                  rsp_bad_s;
  logic                  retire_s;
  logic                  af_nxt_s;

  // The occupancy check uses the pre-cycle count, so a full buffer refuses a
  // request even when the head retires in the same cycle.
  always_comb begin
    alloc_s   = bus.cor_tx_rd_valid & (occ_r != DEPTH_C);
    drop_s    = bus.cor_tx_rd_valid & (occ_r == DEPTH_C);
    rsp_ok_s  = bus.spl_rx_rd_valid & pending_r[bus.spl_rx_rd_tag]
                & ~filled_r[bus.spl_rx_rd_tag];
    rsp_bad_s = bus.spl_rx_rd_valid & ~rsp_ok_s;
    retire_s  = filled_r[head_ptr_r];
    af_nxt_s  = bus.spl_tx_rd_almostfull | ((DEPTH_C - occ_r) <= AF_MARGIN_C);
  end

  // Per-entry state update. Allocation never hits the retiring head (that
  // needs occupancy 0 or DEPTH), and a response to the head only fills it.
  always_comb begin
    pending_nxt_s = pending_r;
    filled_nxt_s  = filled_r;
    if (retire_s) begin
      pending_nxt_s[head_ptr_r] = 1'b0;
      filled_nxt_s[head_ptr_r]  = 1'b0;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (alloc_s) begin
      pending_nxt_s[alloc_ptr_r] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    if (rsp_ok_s) begin
      filled_nxt_s[bus.spl_rx_rd_tag] = 1'b1;
    end else begin
      filled_nxt_s = filled_nxt_s;
    end
  end

  // Occupancy moves by at most one. Allocate and retire together cancel out.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({alloc_s, retire_s})
      2'b10:   occ_nxt_s = occ_r + OCC_ONE_C;
      2'b01:   occ_nxt_s = occ_r - OCC_ONE_C;
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Response data storage. It is left unreset because stale words are never
  // read without a matching filled bit.
  always_ff @(posedge CLK_400M) begin
    if (rsp_ok_s) begin
      data_r[bus.spl_rx_rd_tag] <= bus.spl_rx_data;
    end
  end

  // Control state and registered outputs. A reset abandons all in-flight tags.
  always_ff @(posedge CLK_400M) begin
    if (spl_reset) begin
      pending_r          <= {DEPTH{1'b0}};
      filled_r           <= {DEPTH{1'b0}};
      alloc_ptr_r        <= {TAG_WIDTH{1'b0}};
      head_ptr_r         <= {TAG_WIDTH{1'b0}};
      occ_r              <= {OCC_W{1'b0}};
      bus.io_tx_rd_valid <= 1'b0;
      bus.io_tx_rd_addr  <= {ADDR_WIDTH{1'b0}};
      bus.io_tx_rd_tag   <= {TAG_WIDTH{1'b0}};
      bus.io_rx_rd_valid <= 1'b0;
      bus.io_rx_data     <= {DATA_WIDTH{1'b0}};
      bus.rob_almostfull <= 1'b0;
      bus.rob_err        <= 1'b0;
    end else begin
      pending_r          <= pending_nxt_s;
      filled_r           <= filled_nxt_s;
      occ_r              <= occ_nxt_s;
      bus.io_tx_rd_valid <= alloc_s;
      if (alloc_s) begin
        bus.io_tx_rd_addr <= bus.cor_tx_rd_addr;
        bus.io_tx_rd_tag  <= alloc_ptr_r;
        alloc_ptr_r       <= alloc_ptr_r + TAG_ONE_C;
      end
      bus.io_rx_rd_valid <= retire_s;
      if (retire_s) begin
        bus.io_rx_data <= data_r[head_ptr_r];
        head_ptr_r     <= head_ptr_r + TAG_ONE_C;
      end
      bus.rob_almostfull <= af_nxt_s;
      bus.rob_err        <= bus.rob_err | drop_s | rsp_bad_s;
    end
  end

  assign bus.rob_occupancy = occ_r;
endmodule

// File: tb/tb_rd_reorder_buf.sv
// Directed bench for rd_reorder_buf. Expected values are hand-derived per cycle.
module tb_rd_reorder_buf;
  localparam int TW = 5;
  localparam int AW = 58;
  localparam int DW = 512;

  logic CLK_400M;
  logic spl_reset;
  int   n_vec;
  int   n_err;

  rd_reorder_buf_if #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  rd_reorder_buf #(.TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_MARGIN(4)) dut (
    .CLK_400M (CLK_400M),
    .spl_reset(spl_reset),
    .bus      (bus_if)
  );

  // Free-running clock.
  initial CLK_400M = 1'b0;
  always #5 CLK_400M = ~CLK_400M;

  task automatic check_vec(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_400M);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.cor_tx_rd_valid      = 1'b0;
    bus_if.cor_tx_rd_addr       = {AW{1'b0}};
    bus_if.spl_tx_rd_almostfull = 1'b0;
    bus_if.spl_rx_rd_valid      = 1'b0;
    bus_if.spl_rx_rd_tag        = {TW{1'b0}};
    bus_if.spl_rx_data          = {DW{1'b0}};
  endtask

  task automatic do_reset();
    clear_inputs();
    spl_reset = 1'b1;
    tick();
    spl_reset = 1'b0;
  endtask

  task automatic set_req(input logic v, input logic [AW-1:0] a);
    bus_if.cor_tx_rd_valid = v;
    bus_if.cor_tx_rd_addr  = a;
  endtask

  task automatic set_rsp(input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus_if.spl_rx_rd_valid = v;
    bus_if.spl_rx_rd_tag   = t;
    bus_if.spl_rx_data     = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_vec({pfx, "_tx_valid"}, DW'(bus_if.io_tx_rd_valid), DW'(0));
    check_vec({pfx, "_tx_addr"},  DW'(bus_if.io_tx_rd_addr),  DW'(0));
    check_vec({pfx, "_tx_tag"},   DW'(bus_if.io_tx_rd_tag),   DW'(0));
    check_vec({pfx, "_rx_valid"}, DW'(bus_if.io_rx_rd_valid), DW'(0));
    check_vec({pfx, "_rx_data"},  bus_if.io_rx_data,          DW'(0));
    check_vec({pfx, "_occ"},      DW'(bus_if.rob_occupancy),  DW'(0));
    check_vec({pfx, "_af"},       DW'(bus_if.rob_almostfull), DW'(0));
    check_vec({pfx, "_err"},      DW'(bus_if.rob_err),        DW'(0));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    spl_reset = 1'b1;
    tick();
    tick();
    spl_reset = 1'b0;
    check_reset_outputs("rst");

    // Almost-full pass-through from the I/O queue, one cycle registered.
    bus_if.spl_tx_rd_almostfull = 1'b1;
    tick();
    check_vec("af_pass_on", DW'(bus_if.rob_almostfull), DW'(1));
    bus_if.spl_tx_rd_almostfull = 1'b0;
    tick();
    check_vec("af_pass_off", DW'(bus_if.rob_almostfull), DW'(0));

    // In-order responses.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, AW'(32'h100 + i));
      tick();
      check_vec("io_tx_valid", DW'(bus_if.io_tx_rd_valid), DW'(1));
      check_vec("io_tx_tag",   DW'(bus_if.io_tx_rd_tag),   DW'(i));
      check_vec("io_tx_addr",  DW'(bus_if.io_tx_rd_addr),  DW'(32'h100 + i));
    end
    set_req(1'b0, {AW{1'b0}});
    check_vec("io_occ8", DW'(bus_if.rob_occupancy), DW'(8));
    for (int i = 0; i < 8; i++) begin
      set_rsp(1'b1, TW'(i), DW'(32'h100 + i));
      tick();
      if (i == 0) begin
        check_vec("io_rx_lat", DW'(bus_if.io_rx_rd_valid), DW'(0));
      end else begin
        check_vec("io_rx_valid", DW'(bus_if.io_rx_rd_valid), DW'(1));
        check_vec("io_rx_data",  bus_if.io_rx_data, DW'(32'h100 + i - 1));
      end
    end
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    tick();
    check_vec("io_rx_last", bus_if.io_rx_data, DW'(32'h107));
    check_vec("io_occ0",    DW'(bus_if.rob_occupancy), DW'(0));
    tick();
    check_vec("io_rx_idle", DW'(bus_if.io_rx_rd_valid), DW'(0));
    check_vec("io_err",     DW'(bus_if.rob_err), DW'(0));

    // Reverse-order responses.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, AW'(32'h200 + i));
      tick();
    end
    set_req(1'b0, {AW{1'b0}});
    for (int i = 3; i >= 0; i--) begin
      set_rsp(1'b1, TW'(i), DW'(32'hA0 + i));
      tick();
      check_vec("rev_hold", DW'(bus_if.io_rx_rd_valid), DW'(0));
    end
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    for (int i = 0; i < 4; i++) begin
      tick();
      check_vec("rev_valid", DW'(bus_if.io_rx_rd_valid), DW'(1));
      check_vec("rev_data",  bus_if.io_rx_data, DW'(32'hA0 + i));
    end
    tick();
    check_vec("rev_idle", DW'(bus_if.io_rx_rd_valid), DW'(0));
    check_vec("rev_occ0", DW'(bus_if.rob_occupancy), DW'(0));

    // Fill, back-pressure, drop on full, retire and tag reuse.
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      set_req(1'b1, AW'(i));
      tick();
      if (i == 28) check_vec("fill_af28", DW'(bus_if.rob_almostfull), DW'(0));
      if (i == 29) check_vec("fill_af29", DW'(bus_if.rob_almostfull), DW'(1));
    end
    check_vec("fill_occ32", DW'(bus_if.rob_occupancy), DW'(32));
    check_vec("fill_tag31", DW'(bus_if.io_tx_rd_tag), DW'(31));
    check_vec("fill_err0",  DW'(bus_if.rob_err), DW'(0));
    set_req(1'b1, AW'(32'h999));
    tick();
    check_vec("drop_tx",  DW'(bus_if.io_tx_rd_valid), DW'(0));
    check_vec("drop_err", DW'(bus_if.rob_err), DW'(1));
    check_vec("drop_occ", DW'(bus_if.rob_occupancy), DW'(32));
    check_vec("drop_af",  DW'(bus_if.rob_almostfull), DW'(1));
    set_req(1'b0, {AW{1'b0}});
    set_rsp(1'b1, TW'(0), DW'(32'h5A));
    tick();
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    check_vec("full_rsp_occ", DW'(bus_if.rob_occupancy), DW'(32));
    tick();
    check_vec("full_ret_valid", DW'(bus_if.io_rx_rd_valid), DW'(1));
    check_vec("full_ret_data",  bus_if.io_rx_data, DW'(32'h5A));
    check_vec("full_ret_occ",   DW'(bus_if.rob_occupancy), DW'(31));
    set_req(1'b1, AW'(32'h777));
    tick();
    set_req(1'b0, {AW{1'b0}});
    check_vec("reuse_valid", DW'(bus_if.io_tx_rd_valid), DW'(1));
    check_vec("reuse_tag",   DW'(bus_if.io_tx_rd_tag), DW'(0));
    check_vec("reuse_addr",  DW'(bus_if.io_tx_rd_addr), DW'(32'h777));
    check_vec("reuse_occ",   DW'(bus_if.rob_occupancy), DW'(32));

    // Bogus tag response.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, AW'(32'h400 + i));
      tick();
    end
    set_req(1'b0, {AW{1'b0}});
    set_rsp(1'b1, TW'(9), DW'(32'hBAD));
    tick();
    check_vec("bogus_err",   DW'(bus_if.rob_err), DW'(1));
    check_vec("bogus_rx",    DW'(bus_if.io_rx_rd_valid), DW'(0));
    for (int i = 0; i < 4; i++) begin
      set_rsp(1'b1, TW'(i), DW'(32'hB0 + i));
      tick();
      if (i == 0) begin
        check_vec("bogus_rx_hold", DW'(bus_if.io_rx_rd_valid), DW'(0));
      end else begin
        check_vec("bogus_data", bus_if.io_rx_data, DW'(32'hB0 + i - 1));
      end
    end
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    tick();
    check_vec("bogus_data_last", bus_if.io_rx_data, DW'(32'hB3));

    // Duplicate response must not overwrite.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, AW'(32'h500 + i));
      tick();
    end
    set_req(1'b0, {AW{1'b0}});
    set_rsp(1'b1, TW'(2), DW'(32'hC2));
    tick();
    check_vec("dup_err0", DW'(bus_if.rob_err), DW'(0));
    set_rsp(1'b1, TW'(2), DW'(32'hDEAD));
    tick();
    check_vec("dup_err1", DW'(bus_if.rob_err), DW'(1));
    set_rsp(1'b1, TW'(0), DW'(32'hC0));
    tick();
    set_rsp(1'b1, TW'(1), DW'(32'hC1));
    tick();
    check_vec("dup_d0", bus_if.io_rx_data, DW'(32'hC0));
    set_rsp(1'b1, TW'(3), DW'(32'hC3));
    tick();
    check_vec("dup_d1", bus_if.io_rx_data, DW'(32'hC1));
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    tick();
    check_vec("dup_d2", bus_if.io_rx_data, DW'(32'hC2));
    tick();
    check_vec("dup_d3", bus_if.io_rx_data, DW'(32'hC3));

    // Allocate, respond and retire in one cycle.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, AW'(32'h600 + i));
      tick();
    end
    set_req(1'b0, {AW{1'b0}});
    set_rsp(1'b1, TW'(0), DW'(32'hD0));
    tick();
    set_rsp(1'b1, TW'(1), DW'(32'hD1));
    tick();
    check_vec("sim_pre_data", bus_if.io_rx_data, DW'(32'hD0));
    check_vec("sim_pre_occ",  DW'(bus_if.rob_occupancy), DW'(4));
    set_rsp(1'b1, TW'(2), DW'(32'hD2));
    set_req(1'b1, AW'(32'h605));
    tick();
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    set_req(1'b0, {AW{1'b0}});
    check_vec("sim_occ",      DW'(bus_if.rob_occupancy), DW'(4));
    check_vec("sim_tx_valid", DW'(bus_if.io_tx_rd_valid), DW'(1));
    check_vec("sim_tx_tag",   DW'(bus_if.io_tx_rd_tag), DW'(5));
    check_vec("sim_rx_d1",    bus_if.io_rx_data, DW'(32'hD1));
    tick();
    check_vec("sim_rx_valid2", DW'(bus_if.io_rx_rd_valid), DW'(1));
    check_vec("sim_rx_d2",     bus_if.io_rx_data, DW'(32'hD2));
    check_vec("sim_occ_after", DW'(bus_if.rob_occupancy), DW'(3));

    // Reset with reads outstanding, then a late response.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_req(1'b1, AW'(32'h700 + i));
      tick();
    end
    set_req(1'b0, {AW{1'b0}});
    set_rsp(1'b1, TW'(0), DW'(32'hE0));
    tick();
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    tick();
    check_vec("mid_pre_data", bus_if.io_rx_data, DW'(32'hE0));
    check_vec("mid_pre_occ",  DW'(bus_if.rob_occupancy), DW'(6));
    spl_reset = 1'b1;
    tick();
    spl_reset = 1'b0;
    check_reset_outputs("mid");
    set_rsp(1'b1, TW'(3), DW'(32'hE3));
    tick();
    set_rsp(1'b0, {TW{1'b0}}, {DW{1'b0}});
    check_vec("late_err", DW'(bus_if.rob_err), DW'(1));
    tick();
    check_vec("late_rx",  DW'(bus_if.io_rx_rd_valid), DW'(0));
    check_vec("late_occ", DW'(bus_if.rob_occupancy), DW'(0));
    tick();
    check_vec("late_rx2", DW'(bus_if.io_rx_rd_valid), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
